// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit
//  Description : Operand forwarding select and load-use hazard stall unit for
//                the execute stage.
//                - src_sel picks, per EXE operand, Decode (0), MEM (1) or
//                  WB (2) as the data source; MEM wins over WB.
//                - stall is raised when the load in EXE writes a register
//                  that the Decode instruction reads, and is held for
//                  MEM_LAT cycles in total.
//                - stall_cycles is a saturating count of stalled cycles.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                src_EXE, src_ID     packed operand indices (REG_W each)
//                src_valid_ID        per-operand read enables in Decode
//                dest_*/WB_EN_*      destination / write enable per stage
//                MEM_R_EXE           EXE instruction is a load
//                flush               branch-taken flush
//                src_sel             packed 2-bit per-operand selects
//                stall               pipeline freeze / bubble insert
//                stall_cycles        saturating stall-cycle counter
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int REG_W       = 4,
    parameter int NUM_SRC     = 3,
    parameter int MEM_LAT     = 1,
    parameter int ZERO_REG_EN = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*REG_W-1:0] src_EXE,
    input  logic [NUM_SRC*REG_W-1:0] src_ID,
    input  logic [NUM_SRC-1:0]       src_valid_ID,
    input  logic [REG_W-1:0]         dest_EXE,
    input  logic                     WB_EN_EXE,
    input  logic                     MEM_R_EXE,
    input  logic [REG_W-1:0]         dest_MEM,
    input  logic [REG_W-1:0]         dest_WB,
    input  logic                     WB_EN_MEM,
    input  logic                     WB_EN_WB,
    input  logic                     flush,
    output logic [NUM_SRC*2-1:0]     src_sel,
    output logic                     stall,
    output logic [15:0]              stall_cycles
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;

    // Cycles left in WAIT after the first (IDLE) stall cycle, minus one.
    localparam logic [1:0] c_WAIT_INIT = 2'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

    logic [NUM_SRC-1:0] w_id_hit;
    logic               w_hz;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [1:0]         r_cnt;
    logic [1:0]         w_cnt_nxt;
    logic               w_stall;
    logic [15:0]        r_stall_cycles;

    // ------------------------------------------------------------------------
    // Per-operand forwarding select and Decode-side load-use match
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_W-1:0] w_a_exe;
        logic [REG_W-1:0] w_a_id;
        logic             w_zero_exe;
        logic             w_zero_id;
        logic             w_mem_hit;
        logic             w_wb_hit;

        assign w_a_exe    = src_EXE[i*REG_W +: REG_W];
        assign w_a_id     = src_ID[i*REG_W +: REG_W];
        // With a hard-wired zero register, index 0 is never a producer.
        assign w_zero_exe = (ZERO_REG_EN != 0) && (w_a_exe == '0);
        assign w_zero_id  = (ZERO_REG_EN != 0) && (w_a_id == '0);

        assign w_mem_hit  = WB_EN_MEM && (w_a_exe == dest_MEM) && !w_zero_exe;
        assign w_wb_hit   = WB_EN_WB  && (w_a_exe == dest_WB)  && !w_zero_exe;

        assign src_sel[2*i +: 2] = rst       ? 2'd0 :
                                   w_mem_hit ? 2'd1 :
                                   w_wb_hit  ? 2'd2 : 2'd0;

        assign w_id_hit[i] = src_valid_ID[i] && (w_a_id == dest_EXE) && !w_zero_id;
    end

    assign w_hz = MEM_R_EXE && WB_EN_EXE && (|w_id_hit);

    // ------------------------------------------------------------------------
    // Stall FSM: the first stall cycle is raised combinationally from IDLE;
    // any further cycles are held in WAIT, where new hazards are ignored
    // because EXE already carries a bubble.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            c_IDLE: begin
                // A flush kills the Decode instruction, so its hazard is moot.
                if (w_hz && !flush) begin
                    w_stall = 1'b1;
                    if (MEM_LAT > 1) begin
                        w_state_nxt = c_WAIT;
                        w_cnt_nxt   = c_WAIT_INIT;
                    end
                end
            end
            c_WAIT: begin
                w_stall = 1'b1;
                if (flush || (r_cnt == 2'd0)) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    assign stall = w_stall && !rst;

    // ------------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 16'd0;
        end else if (w_stall && (r_stall_cycles != c_CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the execute pipeline. It selects, per ALU/store operand in EXE, whether the operand comes from Decode, the MEM-stage result or the WB-stage result. It also detects load-use hazards between the load in EXE and the instruction in Decode, and holds a multi-cycle stall for configurable memory latency. It counts stall cycles for performance monitoring.

## Interface

Parameters:
- REG_W, 4: register index width.
- NUM_SRC, 3: operands tracked per instruction (0 = reg1, 1 = reg2, 2 = store source).
- MEM_LAT, 1: stall cycles per load-use hazard; legal range 1..4.
- ZERO_REG_EN, 0: when 1, register index 0 never matches (hard-wired zero).

Ports:
- Timing: one clock; reset is synchronous and active-high.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous active-high reset.
- src_EXE  in  NUM_SRC*REG_W  operand indices of the instruction in EXE; operand i is bits [i*REG_W +: REG_W].
- src_ID  in  NUM_SRC*REG_W  operand indices of the instruction in Decode.
- src_valid_ID  in  NUM_SRC  bit i = operand i of the Decode instruction is actually read.
- dest_EXE  in  REG_W  destination of the instruction in EXE.
- WB_EN_EXE  in  1  EXE instruction writes the register file.
- MEM_R_EXE  in  1  EXE instruction is a load.
- dest_MEM, dest_WB  in  REG_W  destinations in MEM and WB.
- WB_EN_MEM, WB_EN_WB  in  1  write enables in MEM and WB.
- flush  in  1  branch-taken flush of the IF/ID/EXE stages.
- src_sel  out  NUM_SRC*2  per-operand select, same packing; 0 = Decode, 1 = MEM, 2 = WB, 3 never driven.
- stall  out  1  freezes PC and IF/ID; inserts a bubble into EXE.
- stall_cycles  out  16  saturating count of cycles with stall = 1.

## Operation

Match rule:
- Index a matches stage S when S's write enable = 1 and a == dest_S.
- If ZERO_REG_EN = 1, a == 0 never matches.

Forwarding (combinational, per operand i):
- MEM match → 1.
- Else WB match → 2.
- Else → 0.
- MEM has priority over WB when both match.

Load-use detect:
- hz = MEM_R_EXE & (match of dest_EXE, with WB_EN_EXE) against some src_ID[i] with src_valid_ID[i] = 1.

FSM, states IDLE and WAIT, counter cnt of 2 bits:
- IDLE, with hz & ~flush: stall = 1 in the same cycle. If MEM_LAT = 1, stay in IDLE. Else go to WAIT with cnt = MEM_LAT-2.
- IDLE otherwise: stall = 0.
- WAIT: stall = 1. If flush, go to IDLE. Else if cnt == 0, go to IDLE. Else cnt decrements.
- Total stall per hazard is exactly MEM_LAT cycles. Hazard detection is ignored in WAIT, since EXE holds a bubble.

Flush:
- flush has priority over a hazard. A cycle with flush = 1 never asserts stall from IDLE.
- In WAIT, stall is still 1 in the flush cycle; the FSM returns to IDLE next cycle.

Stall counter:
- stall_cycles increments on each clock edge where stall = 1.
- It saturates at 16'hFFFF.

Register file:
- The register file is write-before-read, so values retired past WB need no forwarding.

## Timing

- src_sel is combinational from inputs with zero latency. It is not gated by stall.
- stall is combinational in IDLE and a registered-state function in WAIT.
- Reset (rst = 1 at an edge): state = IDLE, cnt = 0, stall_cycles = 0.
- While rst = 1, stall = 0 and src_sel = 0, regardless of inputs.
- Reset during WAIT aborts the stall; stall = 0 in the following cycle.
- A back-to-back hazard immediately after returning to IDLE is detected normally in that IDLE cycle.

## Test plan

1. Forwarding priority: src_EXE reg1 = 5; dest_MEM = 5 with WB_EN_MEM = 1; dest_WB = 5 with WB_EN_WB = 1 → reg1 sel = 1. Drop WB_EN_MEM → sel = 2. Drop both → 0.
2. Zero register: ZERO_REG_EN = 1, src_EXE = 0, dest_MEM = 0, WB_EN_MEM = 1 → sel = 0. Same case with ZERO_REG_EN = 0 → sel = 1.
3. Load-use, MEM_LAT = 1: MEM_R_EXE = 1, dest_EXE = 3, WB_EN_EXE = 1, src_ID reg2 = 3 valid → stall = 1 for exactly 1 cycle, stall_cycles = 1. With src_valid_ID bit cleared → no stall.
4. Load-use, MEM_LAT = 3: same hazard → stall = 1 for 3 consecutive cycles, then 0; stall_cycles = 3. A flush in the 2nd cycle → stall = 1 in cycles 1-2, 0 in cycle 3; stall_cycles = 2.
5. Simultaneous hazard and flush in IDLE → stall = 0, state stays IDLE, stall_cycles unchanged.
6. Reset mid-WAIT (MEM_LAT = 4, rst in the 2nd stall cycle) → stall = 0 from the reset cycle on, stall_cycles = 0 after the edge. Separately, force 65 540 hazard stall cycles → stall_cycles holds at 16'hFFFF.
